// File: rtl/fft_pkg.sv
// Shared types and constants for the radix-2 butterfly datapath: state encoding and
// the Q1.30 twiddle table (cos / -sin of 2*pi*m/64, m = 0..31) used by every frame size up to 64.
package fft_pkg;

    localparam int DATA_W   = 32;
    localparam int TW_FRAC  = 30;
    localparam int TW_MAX_N = 64;
    localparam int TW_DEPTH = TW_MAX_N / 2;
    localparam int TW_AW    = $clog2(TW_DEPTH);

    typedef enum logic {LOAD, ISSUE} state_t;

    typedef struct packed {
        logic [DATA_W-1:0] re;
        logic [DATA_W-1:0] im;
    } tw_t;

    typedef tw_t [TW_DEPTH-1:0] tw_table_t;

    localparam logic [DATA_W-1:0] TW_ONE = DATA_W'(1 << TW_FRAC);

    // Quarter wave: round(cos(pi*m/32) * 2^30), m = 0..16
    localparam logic [DATA_W-1:0] COS_QTR [0:16] = '{
        TW_ONE,        32'h3FB1_1B48, 32'h3EC5_2FA0, 32'h3D3E_82AE,
        32'h3B20_D79E, 32'h3871_65E3, 32'h3536_CC52, 32'h3179_00D6,
        32'h2D41_3CCD, 32'h2899_E64A, 32'h238E_7673, 32'h1E2B_5D38,
        32'h187D_E2A7, 32'h1294_062F, 32'h0C7C_5C1E, 32'h0645_E9AF,
        32'h0000_0000
    };

    // Second quadrant folds back onto the quarter wave with sign flips.
    function automatic tw_table_t build_tw_table();
        tw_table_t t;
        for (int m = 0; m < TW_DEPTH; m++) begin
            if (m <= 16) begin
                t[TW_AW'(m)].re = COS_QTR[5'(m)];
                t[TW_AW'(m)].im = -COS_QTR[5'(16 - m)];
            end else begin
                t[TW_AW'(m)].re = -COS_QTR[5'(32 - m)];
                t[TW_AW'(m)].im = -COS_QTR[5'(m - 16)];
            end
        end
        return t;
    endfunction

    localparam tw_table_t TW_TABLE = build_tw_table();

endpackage

// File: rtl/butterfly_twiddle_rom.sv
// Twiddle lookup for an N-point frame: k selects W = e^(-j*2*pi*k/N) as Q1.30 cos / -sin.
// Purely combinational; no handshake.
module butterfly_twiddle_rom
    import fft_pkg::*;
#(
    parameter int N = 8
) (
    input  logic [$clog2(N)-2:0] k,
    output logic [DATA_W-1:0]    wr,
    output logic [DATA_W-1:0]    wi
);

    localparam int KW    = $clog2(N) - 1;
    localparam int SHIFT = TW_AW - KW;

    logic [TW_AW-1:0] idx;

    // k * (64/N) maps a small frame onto the 64-point table
    assign idx = TW_AW'(k) << SHIFT;
    assign wr  = TW_TABLE[idx].re;
    assign wi  = TW_TABLE[idx].im;

endmodule

// File: rtl/butterfly_feeder.sv
// Buffers an N-sample frame, then issues the N/2 operand pairs plus twiddle of one DIT stage.
// Pair 0 registers one cycle after the last sample; output holds under !out_ready, one pair/cycle otherwise.
module butterfly_feeder
    import fft_pkg::*;
#(
    parameter int N    = 8,
    parameter int LOGN = $clog2(N)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [LOGN-1:0]   stage,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_re,
    input  logic [DATA_W-1:0] in_im,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] a1,
    output logic [DATA_W-1:0] b1,
    output logic [DATA_W-1:0] a2,
    output logic [DATA_W-1:0] b2,
    output logic [DATA_W-1:0] wr,
    output logic [DATA_W-1:0] wi,
    output logic              out_first,
    output logic              out_last,
    output logic              busy
);

    localparam int              PW        = LOGN - 1;
    localparam logic [LOGN-1:0] STAGE_MAX = LOGN'(LOGN - 1);
    localparam logic [LOGN-1:0] CNT_LAST  = LOGN'(N - 1);
    localparam logic [PW-1:0]   PAIR_LAST = PW'(N / 2 - 1);

    state_t            state;
    logic [LOGN-1:0]   wr_cnt;
    logic [LOGN-1:0]   stage_q;
    logic [LOGN-1:0]   stage_clamp;
    logic [PW-1:0]     p;
    logic [PW-1:0]     sel_p;
    logic [LOGN-1:0]   top_idx;
    logic [LOGN-1:0]   bot_idx;
    logic [PW-1:0]     k_sel;
    logic [DATA_W-1:0] tw_re;
    logic [DATA_W-1:0] tw_im;
    logic [DATA_W-1:0] sbuf_re [N];
    logic [DATA_W-1:0] sbuf_im [N];
    int                s;
    int                pi;
    int                span;
    int                j;
    int                top_i;

    assign in_ready    = (state == LOAD) && !rst;
    assign stage_clamp = (stage > STAGE_MAX) ? STAGE_MAX : stage;

    // Index of the pair to register next: the current one on entry, its successor after a handshake.
    always_comb begin
        sel_p   = out_valid ? p + 1'b1 : p;
        s       = int'(stage_q);
        pi      = int'(sel_p);
        span    = 1 << s;
        j       = pi & (span - 1);
        top_i   = ((pi >> s) << (s + 1)) + j;
        top_idx = LOGN'(top_i);
        bot_idx = LOGN'(top_i + span);
        k_sel   = PW'(j << (PW - s));
    end

    butterfly_twiddle_rom #(.N(N)) u_rom (
        .k  (k_sel),
        .wr (tw_re),
        .wi (tw_im)
    );

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            sbuf_re[wr_cnt] <= in_re;
            sbuf_im[wr_cnt] <= in_im;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= LOAD;
            wr_cnt    <= '0;
            p         <= '0;
            stage_q   <= '0;
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            busy      <= 1'b0;
            a1        <= '0;
            b1        <= '0;
            a2        <= '0;
            b2        <= '0;
            wr        <= '0;
            wi        <= '0;
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        wr_cnt <= wr_cnt + 1'b1;
                        if (wr_cnt == CNT_LAST) begin
                            stage_q <= stage_clamp;
                            p       <= '0;
                            busy    <= 1'b1;
                            state   <= ISSUE;
                        end
                    end
                end
                ISSUE: begin
                    if (!out_valid || out_ready) begin
                        if (out_valid && p == PAIR_LAST) begin
                            out_valid <= 1'b0;
                            out_first <= 1'b0;
                            out_last  <= 1'b0;
                            busy      <= 1'b0;
                            wr_cnt    <= '0;
                            state     <= LOAD;
                        end else begin
                            p         <= sel_p;
                            out_valid <= 1'b1;
                            out_first <= (sel_p == '0);
                            out_last  <= (sel_p == PAIR_LAST);
                            a1        <= sbuf_re[top_idx];
                            b1        <= sbuf_im[top_idx];
                            a2        <= sbuf_re[bot_idx];
                            b2        <= sbuf_im[bot_idx];
                            wr        <= tw_re;
                            wi        <= tw_im;
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_butterfly_feeder.sv
// Bench for butterfly_feeder (N=8): random frames and handshake patterns against a pair-list model.
module tb_butterfly_feeder;

    localparam int  N    = 8;
    localparam int  LOGN = 3;
    localparam real PI   = 3.14159265358979323846;

    typedef struct packed {
        logic [31:0] a1;
        logic [31:0] b1;
        logic [31:0] a2;
        logic [31:0] b2;
        logic [31:0] wr;
        logic [31:0] wi;
        logic        first;
        logic        last;
    } pair_t;

    logic            clk;
    logic            rst;
    logic [LOGN-1:0] stage;
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_re;
    logic [31:0]     in_im;
    logic            out_valid;
    logic            out_ready;
    logic [31:0]     a1, b1, a2, b2, wr, wi;
    logic            out_first;
    logic            out_last;
    logic            busy;

    butterfly_feeder #(.N(N)) dut (
        .clk       (clk),
        .rst       (rst),
        .stage     (stage),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_re     (in_re),
        .in_im     (in_im),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .a1        (a1),
        .b1        (b1),
        .a2        (a2),
        .b2        (b2),
        .wr        (wr),
        .wi        (wi),
        .out_first (out_first),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_chk;
    int          n_pass;
    logic [31:0] mdl_re [N];
    logic [31:0] mdl_im [N];
    pair_t       obs [N/2];
    int          obs_cyc [N/2];
    int          n_obs;
    int          first_vld;
    int          hold_bad;
    int          ir_issue;
    logic [31:0] lit_wr [4] = '{32'h4000_0000, 32'h2D41_3CCD, 32'h0000_0000, 32'hD2BE_C333};
    logic [31:0] lit_wi [4] = '{32'h0000_0000, 32'hD2BE_C333, 32'hC000_0000, 32'hD2BE_C333};

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic pair_t cur_pair();
        return {a1, b1, a2, b2, wr, wi, out_first, out_last};
    endfunction

    function automatic logic [31:0] q30(input real x);
        real y;
        int  v;
        y = x * 1073741824.0;
        if (y >= 0.0) v = $rtoi(y + 0.5);
        else          v = -$rtoi(-y + 0.5);
        return 32'(v);
    endfunction

    // Pairs of a stage are the indices with stage bit clear, in ascending order, each with its partner +span.
    function automatic pair_t model_pair(input int q, input int stg);
        pair_t r;
        int    s, span, cnt, top, bot, k;
        real   ang;
        s    = (stg > LOGN - 1) ? LOGN - 1 : stg;
        span = 1 << s;
        cnt  = 0;
        top  = 0;
        for (int i = 0; i < N; i++) begin
            if (((i >> s) & 1) == 0) begin
                if (cnt == q) top = i;
                cnt++;
            end
        end
        bot     = top + span;
        k       = (top % span) * (N / (2 * span));
        ang     = 2.0 * PI * k / N;
        r.a1    = mdl_re[top];
        r.b1    = mdl_im[top];
        r.a2    = mdl_re[bot];
        r.b2    = mdl_im[bot];
        r.wr    = q30($cos(ang));
        r.wi    = q30(-$sin(ang));
        r.first = (q == 0);
        r.last  = (q == N / 2 - 1);
        return r;
    endfunction

    task automatic load_frame(input int stg, input bit gaps, input bit fixed, input bit hold_iv);
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_re    = fixed ? 32'(i) : $urandom;
            in_im    = fixed ? 32'(-i) : $urandom;
            stage    = LOGN'(stg);
            for (int w = 0; w < 20 && !in_ready; w++) tick();
            mdl_re[i] = in_re;
            mdl_im[i] = in_im;
            tick();
            if (gaps && i != N - 1) begin
                in_valid = 1'b0;
                in_re    = $urandom;
                tick();
            end
        end
        in_valid = hold_iv;
        in_re    = $urandom;
        in_im    = $urandom;
        stage    = LOGN'($urandom);
    endtask

    task automatic issue(input logic [7:0] pat, input int max_pairs);
        logic [2:0] vc;
        bit         stalled;
        pair_t      snap;
        vc        = '0;
        stalled   = 1'b0;
        snap      = '0;
        n_obs     = 0;
        first_vld = -1;
        hold_bad  = 0;
        ir_issue  = 0;
        for (int c = 0; c < 200 && n_obs < max_pairs; c++) begin
            if (stalled && (!out_valid || cur_pair() !== snap)) hold_bad++;
            stalled = 1'b0;
            if (out_valid && in_ready) ir_issue++;
            if (out_valid) begin
                if (first_vld < 0) first_vld = c;
                out_ready = pat[vc];
                vc++;
                if (out_ready) begin
                    obs[n_obs]     = cur_pair();
                    obs_cyc[n_obs] = c;
                    n_obs++;
                end else begin
                    stalled = 1'b1;
                    snap    = cur_pair();
                end
            end else begin
                out_ready = 1'b0;
            end
            if (n_obs == N / 2) in_valid = 1'b0;
            tick();
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_re     = $urandom;
        in_im     = $urandom;
        out_ready = 1'b0;
        stage     = '0;
        for (int c = 0; c < 3; c++) begin
            tick();
            n_chk++;
            if ({in_ready, out_valid, busy, out_first, out_last} !== 5'b0 || {a1, b1, a2, b2, wr, wi} !== '0)
                $display("FAIL reset_cycle%0d: ctl=%b data=%h required all zero", c,
                         {in_ready, out_valid, busy, out_first, out_last}, {a1, b1, a2, b2, wr, wi});
            else n_pass++;
        end
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL reset_release_in_ready: got %b want 1", in_ready);
        else n_pass++;
    endtask

    task automatic test_stage0();
        pair_t e;
        load_frame(0, 1'b0, 1'b1, 1'b0);
        issue(8'hFF, N / 2);
        n_chk++;
        if (first_vld !== 1) $display("FAIL stage0_latency: first valid cycle %0d want 1", first_vld);
        else n_pass++;
        n_chk++;
        if (n_obs !== N / 2) $display("FAIL stage0_count: got %0d pairs want %0d", n_obs, N / 2);
        else n_pass++;
        for (int q = 0; q < n_obs; q++) begin
            e = model_pair(q, 0);
            n_chk++;
            if (obs[q] !== e) $display("FAIL stage0_pair%0d: got %h want %h", q, obs[q], e);
            else n_pass++;
            n_chk++;
            if (obs_cyc[q] !== q + 1) $display("FAIL stage0_cycle%0d: got %0d want %0d", q, obs_cyc[q], q + 1);
            else n_pass++;
        end
        n_chk++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0)
            $display("FAIL stage0_return: in_ready=%b out_valid=%b busy=%b want 1 0 0", in_ready, out_valid, busy);
        else n_pass++;
    endtask

    task automatic test_stage2();
        pair_t e;
        load_frame(2, 1'b0, 1'b1, 1'b0);
        issue(8'hFF, N / 2);
        n_chk++;
        if (n_obs !== N / 2) $display("FAIL stage2_count: got %0d pairs want %0d", n_obs, N / 2);
        else n_pass++;
        for (int q = 0; q < n_obs; q++) begin
            e = model_pair(q, 2);
            n_chk++;
            if (obs[q] !== e) $display("FAIL stage2_pair%0d: got %h want %h", q, obs[q], e);
            else n_pass++;
            n_chk++;
            if (obs[q].wr !== lit_wr[q] || obs[q].wi !== lit_wi[q])
                $display("FAIL stage2_twiddle%0d: got %h/%h want %h/%h", q, obs[q].wr, obs[q].wi, lit_wr[q], lit_wi[q]);
            else n_pass++;
        end
    endtask

    task automatic test_backpressure();
        pair_t e;
        load_frame(1, 1'b0, 1'b0, 1'b0);
        issue(8'hB2, N / 2);
        n_chk++;
        if (n_obs !== N / 2) $display("FAIL bp_count: got %0d pairs want %0d", n_obs, N / 2);
        else n_pass++;
        for (int q = 0; q < n_obs; q++) begin
            e = model_pair(q, 1);
            n_chk++;
            if (obs[q] !== e) $display("FAIL bp_pair%0d: got %h want %h", q, obs[q], e);
            else n_pass++;
        end
        n_chk++;
        if (hold_bad !== 0) $display("FAIL bp_hold: %0d stalled cycles changed, want 0", hold_bad);
        else n_pass++;
        out_ready = 1'b1;
        tick();
        tick();
        out_ready = 1'b0;
        n_chk++;
        if (out_valid !== 1'b0) $display("FAIL bp_extra_pair: out_valid=%b want 0", out_valid);
        else n_pass++;
    endtask

    task automatic test_gaps();
        pair_t e;
        int    stg;
        stg = $urandom_range(0, 2);
        load_frame(stg, 1'b1, 1'b0, 1'b1);
        issue(8'hFF, N / 2);
        n_chk++;
        if (ir_issue !== 0) $display("FAIL gaps_in_ready: high on %0d issue cycles want 0", ir_issue);
        else n_pass++;
        n_chk++;
        if (n_obs !== N / 2) $display("FAIL gaps_count: got %0d pairs want %0d", n_obs, N / 2);
        else n_pass++;
        for (int q = 0; q < n_obs; q++) begin
            e = model_pair(q, stg);
            n_chk++;
            if (obs[q] !== e) $display("FAIL gaps_pair%0d: got %h want %h", q, obs[q], e);
            else n_pass++;
        end
        stg = $urandom_range(0, 2);
        load_frame(stg, 1'b0, 1'b0, 1'b0);
        issue(8'hFF, N / 2);
        for (int q = 0; q < n_obs; q++) begin
            e = model_pair(q, stg);
            n_chk++;
            if (obs[q] !== e) $display("FAIL gaps_next_pair%0d: got %h want %h", q, obs[q], e);
            else n_pass++;
        end
    endtask

    task automatic test_reset_mid();
        pair_t e;
        int    stg;
        load_frame(1, 1'b0, 1'b0, 1'b0);
        issue(8'hFF, 2);
        rst = 1'b1;
        tick();
        n_chk++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || in_ready !== 1'b0)
            $display("FAIL rstmid_in_reset: out_valid=%b busy=%b in_ready=%b want 0 0 0", out_valid, busy, in_ready);
        else n_pass++;
        rst = 1'b0;
        #1;
        n_chk++;
        if (in_ready !== 1'b1) $display("FAIL rstmid_load: in_ready=%b want 1", in_ready);
        else n_pass++;
        stg = $urandom_range(0, 2);
        load_frame(stg, 1'b0, 1'b0, 1'b0);
        issue(8'hFF, N / 2);
        n_chk++;
        if (n_obs !== N / 2) $display("FAIL rstmid_count: got %0d pairs want %0d", n_obs, N / 2);
        else n_pass++;
        for (int q = 0; q < n_obs; q++) begin
            e = model_pair(q, stg);
            n_chk++;
            if (obs[q] !== e) $display("FAIL rstmid_pair%0d: got %h want %h", q, obs[q], e);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        pair_t      e;
        int         stg;
        logic [7:0] pat;
        for (int f = 0; f < 4; f++) begin
            stg = (f == 0) ? 7 : $urandom_range(0, 7);
            pat = 8'($urandom) | 8'h81;
            load_frame(stg, 1'b0, 1'b0, 1'b0);
            issue(pat, N / 2);
            n_chk++;
            if (n_obs !== N / 2) $display("FAIL b2b_count%0d: got %0d pairs want %0d", f, n_obs, N / 2);
            else n_pass++;
            for (int q = 0; q < n_obs; q++) begin
                e = model_pair(q, stg);
                n_chk++;
                if (obs[q] !== e) $display("FAIL b2b_f%0d_pair%0d stage%0d: got %h want %h", f, q, stg, obs[q], e);
                else n_pass++;
            end
            n_chk++;
            if (hold_bad !== 0) $display("FAIL b2b_hold%0d: %0d stalled cycles changed, want 0", f, hold_bad);
            else n_pass++;
        end
    endtask

    initial begin
        n_chk     = 0;
        n_pass    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_re     = '0;
        in_im     = '0;
        out_ready = 1'b0;
        stage     = '0;
        test_reset();
        test_stage0();
        test_stage2();
        test_backpressure();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
